// File: rtl/multiwave_pkg.sv
// Wave-select codes and pipeline latency helper for the multi-wave oscillator.
// Build option: SINE_INTERP_EN (interpolated sine, one extra pipeline stage).
package multiwave_pkg;

    typedef logic [3:0] wave_sel_t;

    localparam wave_sel_t WAVE_SINE  = 4'd0;
    localparam wave_sel_t WAVE_PULSE = 4'd1;
    localparam wave_sel_t WAVE_SAW   = 4'd2;
    localparam wave_sel_t WAVE_TRI   = 4'd3;

    function automatic int unsigned osc_latency();
`ifdef SINE_INTERP_EN
        return 32'd4;
`else
        return 32'd3;
`endif
    endfunction

endpackage

// File: rtl/multiwave_osc_core_if.sv
// Phase-in / sample-out bundle between a voice phase accumulator and the oscillator core.
interface multiwave_osc_core_if #(
    parameter int unsigned PHASE_W  = 10,
    parameter int unsigned SAMPLE_W = 16
);
    import multiwave_pkg::*;

    logic                       phase_valid;
    logic [PHASE_W-1:0]         phase;
    wave_sel_t                  wave_select;
    logic [PHASE_W-1:0]         pulse_width;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample;

    modport master (
        output phase_valid, phase, wave_select, pulse_width,
        input  sample_valid, sample
    );

    modport slave (
        input  phase_valid, phase, wave_select, pulse_width,
        output sample_valid, sample
    );

endinterface

// File: rtl/multiwave_osc_core_quarter_sine_rom.sv
// Quarter-wave sine table, half-step centred so mirroring/negation stay exact; 1-cycle registered read.
// Build option: SINE_INTERP_EN adds a second read port for interpolation.
module quarter_sine_rom #(
    parameter int unsigned LUT_ADDR_W = 8,
    parameter int unsigned SAMPLE_W   = 16
) (
    input  logic                  clk,
    input  logic [LUT_ADDR_W-1:0] addr_a_i,
`ifdef SINE_INTERP_EN
    input  logic [LUT_ADDR_W-1:0] addr_b_i,
    output logic [SAMPLE_W-1:0]   data_b_o,
`endif
    output logic [SAMPLE_W-1:0]   data_a_o
);
    localparam int unsigned DEPTH = 2 ** LUT_ADDR_W;
    localparam real         PI    = 3.14159265358979323846;

    function automatic logic [SAMPLE_W-1:0] rom_entry(int k);
        real max_v;
        real ang;
        max_v = (2.0 ** (SAMPLE_W - 1)) - 1.0;
        ang   = PI / 2.0 * (real'(k) + 0.5) / real'(DEPTH);
        return SAMPLE_W'($rtoi(max_v * $sin(ang) + 0.5));
    endfunction

    logic [SAMPLE_W-1:0] rom_tbl [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
        assign rom_tbl[k] = rom_entry(k);
    end

    always_ff @(posedge clk) begin
        data_a_o <= rom_tbl[addr_a_i];
    end

`ifdef SINE_INTERP_EN
    always_ff @(posedge clk) begin
        data_b_o <= rom_tbl[addr_b_i];
    end
`endif

endmodule

// File: rtl/multiwave_osc_core.sv
// Phase-to-sample oscillator: sine/pulse/saw/triangle with wave/duty changes deferred to phase wrap.
// Build option: SINE_INTERP_EN (interpolated sine, latency 4 instead of 3).
module multiwave_osc_core
    import multiwave_pkg::*;
#(
    parameter int unsigned PHASE_W    = 10,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned LUT_ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    multiwave_osc_core_if.slave osc_if
);
    localparam int unsigned QUART_W = PHASE_W - 2;
    localparam int unsigned FRAC_W  = QUART_W - LUT_ADDR_W;
    localparam int unsigned EXT_W   = PHASE_W + SAMPLE_W;
    localparam logic signed [SAMPLE_W-1:0] MAX_S    = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] NEG_MAX  = -MAX_S;
    localparam logic signed [SAMPLE_W-1:0] MIN_S    = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // Stage 1: input capture and wrap-deferred commit of select/duty
    logic                 s1_valid_q;
    logic [PHASE_W-1:0]   s1_phase_q;
    logic                 have_prev_q;
    wave_sel_t            active_sel_q, active_sel_d;
    logic [PHASE_W-1:0]   active_pw_q, active_pw_d;
    logic                 commit_c;

    always_comb begin
        commit_c     = osc_if.phase_valid && (!have_prev_q || (osc_if.phase < s1_phase_q));
        active_sel_d = commit_c ? osc_if.wave_select : active_sel_q;
        active_pw_d  = commit_c ? osc_if.pulse_width : active_pw_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_phase_q   <= '0;
            have_prev_q  <= 1'b0;
            active_sel_q <= WAVE_SINE;
            active_pw_q  <= '0;
        end else begin
            s1_valid_q   <= osc_if.phase_valid;
            active_sel_q <= active_sel_d;
            active_pw_q  <= active_pw_d;
            if (osc_if.phase_valid) begin
                s1_phase_q  <= osc_if.phase;
                have_prev_q <= 1'b1;
            end
        end
    end

    // Stage 2: ROM address, raw pulse/saw/triangle
    logic [QUART_W-1:0]         quart_c;
    logic [LUT_ADDR_W-1:0]      addr_c;
    logic [EXT_W-1:0]           saw_ext_c, tri_ext_c;
    logic [PHASE_W-2:0]         tri_t_c;
    logic signed [SAMPLE_W-1:0] pulse_c, saw_c, tri_raw_c, tri_c;

    always_comb begin
        quart_c = s1_phase_q[PHASE_W-3:0];
        if (s1_phase_q[PHASE_W-2]) begin
            quart_c = ~quart_c;
        end
        addr_c    = LUT_ADDR_W'(quart_c >> FRAC_W);
        pulse_c   = (s1_phase_q < active_pw_q) ? MAX_S : NEG_MAX;
        saw_ext_c = {s1_phase_q, SAMPLE_W'(0)};
        saw_c     = SAMPLE_W'(saw_ext_c >> PHASE_W) ^ MIN_S;
        tri_t_c   = s1_phase_q[PHASE_W-1] ? ~s1_phase_q[PHASE_W-2:0] : s1_phase_q[PHASE_W-2:0];
        tri_ext_c = {tri_t_c, 1'b0, SAMPLE_W'(0)};
        tri_raw_c = SAMPLE_W'(tri_ext_c >> PHASE_W) ^ MIN_S;
        tri_c     = (tri_raw_c == MIN_S) ? NEG_MAX : tri_raw_c;
    end

    logic                       s2_valid_q, s2_neg_q;
    wave_sel_t                  s2_sel_q;
    logic signed [SAMPLE_W-1:0] s2_pulse_q, s2_saw_q, s2_tri_q;
    logic [SAMPLE_W-1:0]        rom_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_neg_q   <= 1'b0;
            s2_sel_q   <= WAVE_SINE;
            s2_pulse_q <= '0;
            s2_saw_q   <= '0;
            s2_tri_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_neg_q   <= s1_phase_q[PHASE_W-1];
            s2_sel_q   <= active_sel_q;
            s2_pulse_q <= pulse_c;
            s2_saw_q   <= saw_c;
            s2_tri_q   <= tri_c;
        end
    end

    logic                       mux_valid, mux_neg;
    wave_sel_t                  mux_sel;
    logic signed [SAMPLE_W-1:0] mux_pulse, mux_saw, mux_tri, mux_sine;

`ifdef SINE_INTERP_EN
    localparam int unsigned FRAC_W1 = (FRAC_W == 0) ? 1 : FRAC_W;
    localparam int unsigned PROD_W  = SAMPLE_W + FRAC_W1;

    logic [LUT_ADDR_W-1:0] addr_b_c;
    logic [FRAC_W1-1:0]    s2_frac_q;
    logic [SAMPLE_W-1:0]   rom_b, diff_c, interp_c;
    logic [PROD_W-1:0]     prod_c;

    // Second tap saturates at the quarter boundary so the mirror stays exact
    assign addr_b_c = (addr_c == '1) ? addr_c : addr_c + LUT_ADDR_W'(1);

    quarter_sine_rom #(.LUT_ADDR_W(LUT_ADDR_W), .SAMPLE_W(SAMPLE_W)) u_rom (
        .clk      (clk),
        .addr_a_i (addr_c),
        .addr_b_i (addr_b_c),
        .data_b_o (rom_b),
        .data_a_o (rom_a)
    );

    always_comb begin
        diff_c   = rom_b - rom_a;
        prod_c   = PROD_W'(diff_c) * PROD_W'(s2_frac_q);
        interp_c = rom_a + SAMPLE_W'(prod_c >> FRAC_W);
    end

    logic                       s3_valid_q, s3_neg_q;
    wave_sel_t                  s3_sel_q;
    logic signed [SAMPLE_W-1:0] s3_pulse_q, s3_saw_q, s3_tri_q, s3_sine_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_frac_q  <= '0;
            s3_valid_q <= 1'b0;
            s3_neg_q   <= 1'b0;
            s3_sel_q   <= WAVE_SINE;
            s3_pulse_q <= '0;
            s3_saw_q   <= '0;
            s3_tri_q   <= '0;
            s3_sine_q  <= '0;
        end else begin
            s2_frac_q  <= (FRAC_W == 0) ? '0 : FRAC_W1'(quart_c);
            s3_valid_q <= s2_valid_q;
            s3_neg_q   <= s2_neg_q;
            s3_sel_q   <= s2_sel_q;
            s3_pulse_q <= s2_pulse_q;
            s3_saw_q   <= s2_saw_q;
            s3_tri_q   <= s2_tri_q;
            s3_sine_q  <= signed'(interp_c);
        end
    end

    assign mux_valid = s3_valid_q;
    assign mux_neg   = s3_neg_q;
    assign mux_sel   = s3_sel_q;
    assign mux_pulse = s3_pulse_q;
    assign mux_saw   = s3_saw_q;
    assign mux_tri   = s3_tri_q;
    assign mux_sine  = s3_sine_q;
`else
    quarter_sine_rom #(.LUT_ADDR_W(LUT_ADDR_W), .SAMPLE_W(SAMPLE_W)) u_rom (
        .clk      (clk),
        .addr_a_i (addr_c),
        .data_a_o (rom_a)
    );

    assign mux_valid = s2_valid_q;
    assign mux_neg   = s2_neg_q;
    assign mux_sel   = s2_sel_q;
    assign mux_pulse = s2_pulse_q;
    assign mux_saw   = s2_saw_q;
    assign mux_tri   = s2_tri_q;
    assign mux_sine  = signed'(rom_a);
`endif

    // Output stage: select mux, sine quadrant sign; sample holds across bubbles
    logic signed [SAMPLE_W-1:0] wave_c, sample_d, sample_q;
    logic                       sample_valid_q;

    always_comb begin
        wave_c = mux_pulse;
        case (mux_sel)
            WAVE_SINE: wave_c = mux_neg ? -mux_sine : mux_sine;
            WAVE_SAW:  wave_c = mux_saw;
            WAVE_TRI:  wave_c = mux_tri;
            default:   wave_c = mux_pulse;
        endcase
        sample_d = mux_valid ? wave_c : sample_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_q       <= sample_d;
            sample_valid_q <= mux_valid;
        end
    end

    assign osc_if.sample       = sample_q;
    assign osc_if.sample_valid = sample_valid_q;

endmodule
